point_integrator: RTL

//  Consumer end of the spring-force stream. Sums the signed force beats from all springs on one point mass,

---
 rtl/physics_pkg.sv | 29 ++
 rtl/point_integrator_sat_add_shift.sv | 23 ++
 rtl/point_integrator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/physics_pkg.sv
// Shared types and helpers for the mass-spring physics pipeline.
package physics_pkg;

    // Integrator step phases: gather force beats, update velocity, update position, publish.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        VEL   = 2'd1,
        POS   = 2'd2,
        DONE  = 2'd3
    } integ_state_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    // The caller narrows the result with a size cast; the upper bits are then pure sign copies.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                     input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/point_integrator_sat_add_shift.sv
// Saturating "base + (delta >>> SHIFT)" used for both the velocity and the position updates.
// Purely combinational; the shift is arithmetic, so negative deltas round toward -inf.
module sat_add_shift
    import physics_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [OUT_W-1:0] i_base,
    input  logic signed [IN_W-1:0]  i_delta,
    output logic signed [OUT_W-1:0] o_sum
);

    logic signed [63:0] w_base_ext;
    logic signed [63:0] w_delta_shift;

    // Widen both operands far enough that the add cannot wrap before clamping.
    assign w_base_ext    = 64'(i_base);
    assign w_delta_shift = 64'(i_delta) >>> SHIFT;
    assign o_sum         = OUT_W'(sat_trunc(w_base_ext + w_delta_shift, OUT_W));

endmodule

// File: rtl/point_integrator.sv
// Point-mass integrator: sums spring force beats plus gravity, then performs a
// semi-implicit Euler step (velocity first, position from the new velocity) with a floor clamp.
module point_integrator
    import physics_pkg::*;
#(
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int FORCE_SIZE    = 16,
    parameter int MAX_SPRINGS   = 8,
    parameter int DT_SHIFT      = 4,
    parameter int MASS_SHIFT    = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            force_valid,
    output logic                            force_ready,
    input  logic signed [FORCE_SIZE-1:0]    force_x,
    input  logic signed [FORCE_SIZE-1:0]    force_y,
    input  logic                            force_last,
    input  logic signed [FORCE_SIZE-1:0]    gravity_y,
    input  logic signed [POSITION_SIZE-1:0] floor_y,
    input  logic                            load_init,
    input  logic signed [POSITION_SIZE-1:0] pos_init_x,
    input  logic signed [POSITION_SIZE-1:0] pos_init_y,
    output logic signed [POSITION_SIZE-1:0] pos_x,
    output logic signed [POSITION_SIZE-1:0] pos_y,
    output logic signed [VELOCITY_SIZE-1:0] vel_x,
    output logic signed [VELOCITY_SIZE-1:0] vel_y,
    output logic                            state_valid,
    output logic                            overflow
);

    localparam int CNT_W = $clog2(MAX_SPRINGS + 1);
    localparam int ACC_W = FORCE_SIZE + CNT_W + 1;

    // Axis index 0 = x, 1 = y throughout.
    integ_state_t                   r_state;
    logic signed [ACC_W-1:0]        r_acc [2];
    logic [CNT_W-1:0]               r_cnt;
    logic signed [POSITION_SIZE-1:0] r_pos [2];
    logic signed [VELOCITY_SIZE-1:0] r_vel [2];
    logic                           r_state_valid;
    logic                           r_overflow;

    logic                           w_beat;
    logic [CNT_W-1:0]               w_cnt_inc;
    logic                           w_cnt_full;
    logic signed [FORCE_SIZE-1:0]   w_force [2];
    logic signed [ACC_W-1:0]        w_acc_sum [2];
    logic signed [ACC_W-1:0]        w_acc_y_grav;
    logic signed [ACC_W-1:0]        w_vel_delta [2];
    logic signed [VELOCITY_SIZE-1:0] w_vel_n [2];
    logic signed [POSITION_SIZE-1:0] w_pos_n [2];

    // Beats are only taken while gathering and never in a cycle that reloads the point.
    assign force_ready = rst_in & (r_state == ACCUM) & ~load_init;
    assign w_beat      = force_valid & force_ready;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_cnt_full  = (w_cnt_inc == CNT_W'(MAX_SPRINGS));

    assign w_force[0] = force_x;
    assign w_force[1] = force_y;

    // Gravity joins the y sum on the way into the velocity update.
    assign w_acc_y_grav   = ACC_W'(sat_trunc(64'(r_acc[1]) + 64'(gravity_y), ACC_W));
    assign w_vel_delta[0] = r_acc[0];
    assign w_vel_delta[1] = w_acc_y_grav;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            // Running force sum saturates instead of wrapping.
            assign w_acc_sum[gi] = ACC_W'(sat_trunc(64'(r_acc[gi]) + 64'(w_force[gi]), ACC_W));

            // v' = sat(v + F * dt / m)
            sat_add_shift #(
                .IN_W  (ACC_W),
                .OUT_W (VELOCITY_SIZE),
                .SHIFT (DT_SHIFT + MASS_SHIFT)
            ) u_vel (
                .i_base  (r_vel[gi]),
                .i_delta (w_vel_delta[gi]),
                .o_sum   (w_vel_n[gi])
            );

            // p' = sat(p + v' * dt); r_vel already holds v' when this is consumed in POS.
            sat_add_shift #(
                .IN_W  (VELOCITY_SIZE),
                .OUT_W (POSITION_SIZE),
                .SHIFT (DT_SHIFT)
            ) u_pos (
                .i_base  (r_pos[gi]),
                .i_delta (r_vel[gi]),
                .o_sum   (w_pos_n[gi])
            );
        end
    endgenerate

    // Step sequencer: holds every piece of state; load_init overrides any phase.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= ACCUM;
            r_acc[0]      <= '0;
            r_acc[1]      <= '0;
            r_cnt         <= '0;
            r_pos[0]      <= '0;
            r_pos[1]      <= '0;
            r_vel[0]      <= '0;
            r_vel[1]      <= '0;
            r_state_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (load_init) begin
            r_state       <= ACCUM;
            r_acc[0]      <= '0;
            r_acc[1]      <= '0;
            r_cnt         <= '0;
            r_pos[0]      <= pos_init_x;
            r_pos[1]      <= pos_init_y;
            r_vel[0]      <= '0;
            r_vel[1]      <= '0;
            r_state_valid <= 1'b0;
        end else begin
            r_state_valid <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_beat) begin
                        r_acc[0] <= w_acc_sum[0];
                        r_acc[1] <= w_acc_sum[1];
                        r_cnt    <= w_cnt_inc;
                        if (force_last || w_cnt_full) begin
                            r_state <= VEL;
                            // Hitting the beat limit without a closing beat means springs were dropped.
                            if (!force_last) begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                end
                VEL: begin
                    r_acc[1] <= w_acc_y_grav;
                    r_vel[0] <= w_vel_n[0];
                    r_vel[1] <= w_vel_n[1];
                    r_state  <= POS;
                end
                POS: begin
                    r_pos[0] <= w_pos_n[0];
                    if (w_pos_n[1] < floor_y) begin
                        // Ground contact: pin to the floor and kill only downward motion.
                        r_pos[1] <= floor_y;
                        if (r_vel[1][VELOCITY_SIZE-1]) begin
                            r_vel[1] <= '0;
                        end
                    end else begin
                        r_pos[1] <= w_pos_n[1];
                    end
                    r_state_valid <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    r_acc[0] <= '0;
                    r_acc[1] <= '0;
                    r_cnt    <= '0;
                    r_state  <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign pos_x       = r_pos[0];
    assign pos_y       = r_pos[1];
    assign vel_x       = r_vel[0];
    assign vel_y       = r_vel[1];
    assign state_valid = r_state_valid;
    assign overflow    = r_overflow;

endmodule
